bitfile_loader: RTL and testbench
=================================

Name: bitfile_loader

Overview:
Serial configuration port that produces the 8-bit bitfile word consumed by the Controller. It receives a framed bitstream one bit at a time: sync word, payload, then checksum. It commits the payload to its parallel output only when the checksum passes. It sits between the external programming interface and the Controller's bitfile input.

Parameters:
CFG_WIDTH, 8, payload width in bits; must be a multiple of 8.
SYNC_WORD, 8'hA5, frame start pattern.
DEFAULT_CFG, {CFG_WIDTH{1'b0}}, value of bitfile_out after reset.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  reset; asynchronous, active-low (reset=0 resets).
cfg_din  in  1  serial data bit, MSB first.
cfg_din_valid  in  1  cfg_din is sampled only on edges where this is 1.
cfg_abort  in  1  synchronous abort; returns to HUNT.
bitfile_out  out  CFG_WIDTH  committed configuration word, drives the Controller's bitfile input.
cfg_done  out  1  one-cycle pulse on a successful commit.
cfg_err  out  1  one-cycle pulse on a checksum mismatch.
busy  out  1  high in LOAD and CHECK.
cfg_loaded  out  1  level; high once any frame has been committed since reset.

Behaviour:
- Reset (reset=0, async):
  - State goes to HUNT; shift, shadow and checksum registers go to 0.
  - bitfile_out=DEFAULT_CFG; cfg_done=cfg_err=busy=cfg_loaded=0.
  - Reset during LOAD or CHECK discards the frame, and bitfile_out returns to DEFAULT_CFG.
- States: HUNT, LOAD, CHECK. All transitions happen only on valid-bit edges, except abort.
- HUNT:
  - An 8-bit sliding register shifts in cfg_din on each valid bit.
  - On the edge where {reg[6:0],cfg_din}==SYNC_WORD: go to LOAD, clear the bit counter and checksum.
  - The register is cleared on entry to HUNT, so a new sync needs 8 fresh bits.
- LOAD:
  - Shift cfg_din into the shadow register, MSB first.
  - Counter runs 0..CFG_WIDTH-1. After bit CFG_WIDTH-1, go to CHECK.
  - Sync patterns inside the payload are not interpreted.
- Checksum: 8-bit XOR of all payload bytes. Byte 0 is the first byte received.
- CHECK:
  - Shift in 8 checksum bits.
  - On the edge sampling the 8th bit, compare against the computed XOR.
    - Match: bitfile_out<=shadow, cfg_done=1 for exactly that following cycle, cfg_loaded<=1, go to HUNT.
    - Mismatch: bitfile_out unchanged, cfg_err=1 for one cycle, go to HUNT.
- Latency: bitfile_out is visible one clock edge after the final checksum bit is sampled. Between commits it is fully stable.
- cfg_din_valid=0 cycles: no state, counter or register change. Gaps of any length are legal mid-frame.
- cfg_abort=1 (any state):
  - Next state is HUNT and the partial frame is discarded; bitfile_out is unchanged.
  - Abort takes priority over a simultaneous valid bit, including the final checksum bit, so no commit and no cfg_err occur.
- cfg_done and cfg_err are never high together.
- busy=1 exactly when the state is LOAD or CHECK.

Decomposition:
- Shared package cfg_pkg:
  - State encoding (HUNT=2'd0, LOAD=2'd1, CHECK=2'd2).
  - SYNC_WORD default.
  - CHECKSUM_W=8.
- One natural sub-module, cfg_xor_accum:
  - Byte assembler plus running XOR.
  - Inputs: clear, bit, bit_valid. Outputs: checksum, byte_done.

Test Plan:
1. Default config: after reset, stream A5,1B,1B (CFG_WIDTH=8) on continuous valid -> bitfile_out=8'h1B one edge after the 24th bit, cfg_done pulse, cfg_loaded=1.
2. Bad checksum: after a loaded 0x1B, stream A5,3C,3D -> cfg_err single pulse, bitfile_out stays 0x1B, cfg_done stays 0, state HUNT.
3. Sync hunt: leading bits 1,0,1 then A5,5A,5A -> bitfile_out=0x5A. Also send payload 0xA5 with checksum 0xA5 -> committed as 0xA5, not treated as a resync.
4. Valid gaps: same frame as scenario 1 with random cfg_din_valid=0 gaps (1-7 cycles) -> identical result. Toggling cfg_din during gaps has no effect.
5. Abort/reset: cfg_abort after 4 payload bits -> busy drops the next cycle, bitfile_out unchanged. Abort coincident with the final checksum bit -> no commit, no cfg_err. Reset=0 mid-LOAD -> bitfile_out=DEFAULT_CFG immediately (async).
6. CFG_WIDTH=16: stream A5,12,34,26 -> bitfile_out=16'h1234, cfg_done. Checksum 27 -> cfg_err, no commit.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants for the serial bitfile loader: FSM encoding, sync word default
// and checksum width.
package cfg_pkg;
    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam int         CHECKSUM_W    = 8;
    localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
endpackage

// File: rtl/cfg_xor_accum.sv
// Byte assembler with a running XOR over every completed payload byte.
module cfg_xor_accum
    import cfg_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic [CHECKSUM_W-1:0] checksum,
    output logic                  byte_done
);
    localparam int BC_W = $clog2(CHECKSUM_W);

    logic [CHECKSUM_W-2:0] byte_sr;
    logic [BC_W-1:0]       bcnt;
    logic [CHECKSUM_W-1:0] next_byte;

    assign next_byte = {byte_sr, bit_in};
    assign byte_done = bit_valid && !clear && (bcnt == BC_W'(CHECKSUM_W-1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_sr  <= '0;
            bcnt     <= '0;
            checksum <= '0;
        end else if (clear) begin
            byte_sr  <= '0;
            bcnt     <= '0;
            checksum <= '0;
        end else if (bit_valid) begin
            byte_sr <= next_byte[CHECKSUM_W-2:0];
            bcnt    <= bcnt + 1'b1;
            if (byte_done)
                checksum <= checksum ^ next_byte;
        end
    end
endmodule

// File: rtl/bitfile_loader.sv
// Serial configuration port: hunts for a sync word, loads a payload MSB first and
// commits it to bitfile_out only when the trailing XOR checksum matches.
module bitfile_loader
    import cfg_pkg::*;
#(
    parameter int                   CFG_WIDTH   = 8,
    parameter logic [7:0]           SYNC_WORD   = SYNC_WORD_DEF,
    parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_din,
    input  logic                 cfg_din_valid,
    input  logic                 cfg_abort,
    output logic [CFG_WIDTH-1:0] bitfile_out,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic                 busy,
    output logic                 cfg_loaded
);
    localparam int CNT_W = $clog2(CFG_WIDTH);

    logic [1:0]            state;
    // Only 7 bits are stored: the 8-bit window is completed by the incoming bit.
    logic [6:0]            hunt_sr;
    logic [CHECKSUM_W-2:0] chk_sr;
    logic [2:0]            chk_cnt;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CFG_WIDTH-1:0]  shadow;
    logic [7:0]            hunt_next;
    logic [CHECKSUM_W-1:0] chk_word;
    logic [CHECKSUM_W-1:0] checksum;
    logic                  byte_done;
    logic                  acc_clear;
    logic                  acc_valid;
    logic                  last_bit;

    assign hunt_next = {hunt_sr, cfg_din};
    assign chk_word  = {chk_sr, cfg_din};
    assign last_bit  = (bit_cnt == CNT_W'(CFG_WIDTH-1));
    assign acc_clear = (state == ST_HUNT) || cfg_abort;
    assign acc_valid = cfg_din_valid && (state == ST_LOAD);
    assign busy      = (state != ST_HUNT);

    cfg_xor_accum u_accum (
        .clk       (clk),
        .reset     (reset),
        .clear     (acc_clear),
        .bit_in    (cfg_din),
        .bit_valid (acc_valid),
        .checksum  (checksum),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_HUNT;
            hunt_sr     <= '0;
            chk_sr      <= '0;
            chk_cnt     <= '0;
            bit_cnt     <= '0;
            shadow      <= '0;
            bitfile_out <= DEFAULT_CFG;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            cfg_loaded  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            // Abort wins over any simultaneous bit, including the last checksum bit.
            if (cfg_abort) begin
                state   <= ST_HUNT;
                hunt_sr <= '0;
                bit_cnt <= '0;
                chk_cnt <= '0;
            end else if (cfg_din_valid) begin
                case (state)
                    ST_HUNT: begin
                        if (hunt_next == SYNC_WORD) begin
                            state   <= ST_LOAD;
                            hunt_sr <= '0;
                            bit_cnt <= '0;
                        end else begin
                            hunt_sr <= hunt_next[6:0];
                        end
                    end
                    ST_LOAD: begin
                        shadow  <= {shadow[CFG_WIDTH-2:0], cfg_din};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_done && last_bit) begin
                            state   <= ST_CHECK;
                            chk_cnt <= '0;
                        end
                    end
                    ST_CHECK: begin
                        chk_sr  <= chk_word[CHECKSUM_W-2:0];
                        chk_cnt <= chk_cnt + 1'b1;
                        if (chk_cnt == 3'd7) begin
                            state   <= ST_HUNT;
                            hunt_sr <= '0;
                            if (chk_word == checksum) begin
                                bitfile_out <= shadow;
                                cfg_done    <= 1'b1;
                                cfg_loaded  <= 1'b1;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bitfile_loader.sv
// Directed bench for bitfile_loader: a frame table for the 8-bit instance plus
// hand-written abort, reset, sync-hunt and 16-bit sequences.
module tb_bitfile_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cfg_din = 1'b0;
    logic cfg_din_valid = 1'b0;
    logic cfg_abort = 1'b0;

    logic [7:0]  out8;
    logic        done8, err8, busy8, loaded8;
    logic [15:0] out16;
    logic        done16, err16, busy16, loaded16;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bitfile_loader #(.CFG_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .cfg_din(cfg_din), .cfg_din_valid(cfg_din_valid),
        .cfg_abort(cfg_abort), .bitfile_out(out8), .cfg_done(done8), .cfg_err(err8),
        .busy(busy8), .cfg_loaded(loaded8)
    );

    bitfile_loader #(.CFG_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .cfg_din(cfg_din), .cfg_din_valid(cfg_din_valid),
        .cfg_abort(cfg_abort), .bitfile_out(out16), .cfg_done(done16), .cfg_err(err16),
        .busy(busy16), .cfg_loaded(loaded16)
    );

    typedef struct {
        logic [7:0] pay;
        logic [7:0] chk;
        logic       done;
        logic       err;
        logic [7:0] out;
        bit         gaps;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input bit gaps);
        if (gaps && ($urandom_range(0, 1) == 1)) begin
            int n;
            n = $urandom_range(1, 7);
            repeat (n) begin
                @(negedge clk);
                cfg_din_valid = 1'b0;
                cfg_din = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        cfg_din = b;
        cfg_din_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    // Sample the cycle after the last checksum bit, then confirm the pulse ended.
    task automatic post8(input string name, input logic done, input logic err, input logic [7:0] out);
        @(negedge clk);
        cfg_din_valid = 1'b0;
        check({name, "_done"}, done8, done);
        check({name, "_err"}, err8, err);
        check({name, "_out"}, out8, out);
        check({name, "_busy"}, busy8, 0);
        @(negedge clk);
        check({name, "_done_off"}, done8, 0);
        check({name, "_err_off"}, err8, 0);
    endtask

    task automatic post16(input string name, input logic done, input logic err,
                          input logic [15:0] out, input logic loaded);
        @(negedge clk);
        cfg_din_valid = 1'b0;
        check({name, "_done"}, done16, done);
        check({name, "_err"}, err16, err);
        check({name, "_out"}, out16, out);
        check({name, "_loaded"}, loaded16, loaded);
        @(negedge clk);
        check({name, "_done_off"}, done16, 0);
        check({name, "_err_off"}, err16, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h1B, 8'h1B, 1'b1, 1'b0, 8'h1B, 1'b0};
        vecs[1] = '{8'h3C, 8'h3D, 1'b0, 1'b1, 8'h1B, 1'b0};
        vecs[2] = '{8'hA5, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0};
        vecs[3] = '{8'hFF, 8'hFE, 1'b0, 1'b1, 8'hA5, 1'b0};
        vecs[4] = '{8'h1B, 8'h1B, 1'b1, 1'b0, 8'h1B, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out8, 8'h00);
        check("rst_done", done8, 0);
        check("rst_err", err8, 0);
        check("rst_busy", busy8, 0);
        check("rst_loaded", loaded8, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 6; v++) begin
            send_byte(8'hA5, vecs[v].gaps);
            send_byte(vecs[v].pay, vecs[v].gaps);
            #1;
            check($sformatf("v%0d_busy_mid", v), busy8, 1);
            send_byte(vecs[v].chk, vecs[v].gaps);
            post8($sformatf("v%0d", v), vecs[v].done, vecs[v].err, vecs[v].out);
            check($sformatf("v%0d_loaded", v), loaded8, 1);
        end

        // Sync hunt with leading junk bits
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
        send_byte(8'hA5, 0); send_byte(8'h5A, 0); send_byte(8'h5A, 0);
        post8("hunt", 1'b1, 1'b0, 8'h5A);

        // Abort after 4 payload bits
        send_byte(8'hA5, 0);
        send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        #1;
        check("abort_busy_before", busy8, 1);
        @(negedge clk);
        cfg_din_valid = 1'b0;
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("abort_busy_after", busy8, 0);
        check("abort_out", out8, 8'h5A);
        check("abort_done", done8, 0);

        // Abort coincident with the final checksum bit of an otherwise good frame
        send_byte(8'hA5, 0);
        send_byte(8'h77, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
        @(negedge clk);
        cfg_din = 1'b1;
        cfg_din_valid = 1'b1;
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        cfg_din_valid = 1'b0;
        check("abort_last_done", done8, 0);
        check("abort_last_err", err8, 0);
        check("abort_last_out", out8, 8'h5A);
        check("abort_last_busy", busy8, 0);

        // Recovery after abort
        send_byte(8'hA5, 0); send_byte(8'h3C, 0); send_byte(8'h3C, 0);
        post8("recover", 1'b1, 1'b0, 8'h3C);

        // Async reset mid-LOAD
        send_byte(8'hA5, 0);
        send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
        @(negedge clk);
        cfg_din_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("areset_out", out8, 8'h00);
        check("areset_busy", busy8, 0);
        check("areset_loaded", loaded8, 0);
        @(negedge clk);
        reset = 1'b1;

        // 16-bit instance
        send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h27, 0);
        post16("w16_bad", 1'b0, 1'b1, 16'h0000, 1'b0);
        send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h26, 0);
        post16("w16_good", 1'b1, 1'b0, 16'h1234, 1'b1);
        send_byte(8'hA5, 0); send_byte(8'h56, 0); send_byte(8'h78, 0); send_byte(8'h27, 0);
        post16("w16_bad2", 1'b0, 1'b1, 16'h1234, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
